// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter sharing one UART byte transmitter
// among NUM_REQ sources, with length-limit and idle-timeout forced release.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int MAX_MSG_BYTES = 64,
    parameter int IDLE_TIMEOUT  = 86800
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    input  logic                 tx_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 timeout_evt,
    output logic                 trunc_evt,
    output logic                 dbg_state
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_MSG_BYTES + 1);
    localparam int IDL_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;

    // Handshake: a byte moves on any cycle where tx_valid & tx_ready; the owner
    // must hold its byte stable while valid, and req_ready only reaches the owner.
    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   last_ptr, last_ptr_nxt;
    logic [PTR_W-1:0]   owner, owner_nxt;
    logic [CNT_W-1:0]   byte_cnt, byte_cnt_nxt;
    logic [IDL_W-1:0]   idle_cnt, idle_cnt_nxt;
    logic [NUM_REQ-1:0] grant_nxt;
    logic               timeout_nxt, trunc_nxt;

    logic               sel_found;
    logic [PTR_W-1:0]   sel_idx;
    logic [PTR_W-1:0]   cand;
    logic               own_valid, own_last, xfer, release_now;

    assign own_valid = req_valid[owner];
    assign own_last  = req_last[owner];
    assign xfer      = (state == S_LOCKED) && own_valid && tx_ready;

    // Search starts just after the previous owner so every waiting peer gets a turn.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = PTR_W'((int'(last_ptr) + k) % NUM_REQ);
            if (!sel_found && req_valid[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            grant       <= '0;
            last_ptr    <= PTR_W'(NUM_REQ - 1);
            owner       <= '0;
            byte_cnt    <= '0;
            idle_cnt    <= '0;
            timeout_evt <= 1'b0;
            trunc_evt   <= 1'b0;
        end else begin
            state       <= state_nxt;
            grant       <= grant_nxt;
            last_ptr    <= last_ptr_nxt;
            owner       <= owner_nxt;
            byte_cnt    <= byte_cnt_nxt;
            idle_cnt    <= idle_cnt_nxt;
            timeout_evt <= timeout_nxt;
            trunc_evt   <= trunc_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        last_ptr_nxt = last_ptr;
        owner_nxt    = owner;
        byte_cnt_nxt = byte_cnt;
        idle_cnt_nxt = idle_cnt;
        timeout_nxt  = 1'b0;
        trunc_nxt    = 1'b0;
        release_now  = 1'b0;
        case (state)
            S_IDLE: begin
                if (sel_found) begin
                    state_nxt    = S_LOCKED;
                    owner_nxt    = sel_idx;
                    grant_nxt    = NUM_REQ'(1) << sel_idx;
                    byte_cnt_nxt = '0;
                    idle_cnt_nxt = '0;
                end
            end
            S_LOCKED: begin
                if (xfer) begin
                    byte_cnt_nxt = byte_cnt + 1'b1;
                    idle_cnt_nxt = '0;
                    // last wins over the length limit when both land on one byte
                    if (own_last) begin
                        release_now = 1'b1;
                    end else if (byte_cnt == CNT_W'(MAX_MSG_BYTES - 1)) begin
                        release_now = 1'b1;
                        trunc_nxt   = 1'b1;
                    end
                end else if (own_valid) begin
                    idle_cnt_nxt = '0;
                end else if (idle_cnt == IDL_W'(IDLE_TIMEOUT - 1)) begin
                    release_now = 1'b1;
                    timeout_nxt = 1'b1;
                end else begin
                    idle_cnt_nxt = idle_cnt + 1'b1;
                end
                if (release_now) begin
                    state_nxt    = S_IDLE;
                    grant_nxt    = '0;
                    last_ptr_nxt = owner;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        req_ready = grant & {NUM_REQ{tx_ready}};
        dbg_state = state;
        if (state == S_LOCKED) begin
            tx_valid = own_valid;
            tx_data  = req_data[{owner, 3'b000} +: 8];
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised scoreboard bench for uart_tx_arbiter: a message-level model
// predicts byte order, owners, release events and grant timing.
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int MAXB  = 4;
    localparam int IDLET = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_last, req_ready, grant;
    logic [8*N-1:0] req_data;
    logic           tx_valid, tx_ready, timeout_evt, trunc_evt, dbg_state;
    logic [7:0]     tx_data;

    uart_tx_arbiter #(.NUM_REQ(N), .MAX_MSG_BYTES(MAXB), .IDLE_TIMEOUT(IDLET)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_valid(tx_valid),
        .tx_data(tx_data), .tx_ready(tx_ready), .grant(grant),
        .timeout_evt(timeout_evt), .trunc_evt(trunc_evt), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- shared state ----------------
    int compared = 0;
    int mismatched = 0;
    logic [N+7:0] exp_q[$];
    logic [1:0]   exp_evt_q[$];
    logic [8:0]   strm [N][$];
    logic [8:0]   stg  [N][$];
    logic [8:0]   mdl  [N][$];
    int  model_last = N - 1;
    int  tx_mode = 0;
    bit  gaps_en = 0;
    bit  mon_en = 0;
    bit  rise_pend = 0;
    int  rise_cyc = 0;
    int  xfer_seen = 0;
    int  gap_cnt [N];
    bit  stalled [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // ---------------- driver ----------------
    initial begin : driver
        int pat_i;
        logic [3:0] pat;
        pat_i = 0;
        pat = 4'b1001;
        req_valid = '0; req_data = '0; req_last = '0; tx_ready = 1'b0;
        for (int i = 0; i < N; i++) begin gap_cnt[i] = 0; stalled[i] = 0; end
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                stalled[i] = req_valid[i] && !req_ready[i];
                if (req_valid[i] && req_ready[i] && strm[i].size() > 0)
                    void'(strm[i].pop_front());
            end
            @(posedge clk);
            #1;
            case (tx_mode)
                0: tx_ready = 1'b1;
                1: begin tx_ready = pat[pat_i]; pat_i = (pat_i + 1) % 4; end
                default: tx_ready = ($urandom_range(0, 3) != 0);
            endcase
            for (int i = 0; i < N; i++) begin
                if (gap_cnt[i] > 0) gap_cnt[i]--;
                else if (gaps_en && grant[i] && !stalled[i] && $urandom_range(0, 7) == 0)
                    gap_cnt[i] = $urandom_range(1, 4);
                if (strm[i].size() > 0 && !(grant[i] && gap_cnt[i] > 0)) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = strm[i][0][7:0];
                    req_last[i]        = strm[i][0][8];
                end else begin
                    req_valid[i]       = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                    req_last[i]        = 1'b0;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    task automatic add_str(input int r, input string s, input bit l);
        for (int i = 0; i < s.len(); i++)
            stg[r].push_back({(l && (i == s.len() - 1)), s[i]});
    endtask

    task automatic add_rand(input int r, input int len, input bit l);
        for (int i = 0; i < len; i++)
            stg[r].push_back({(l && (i == len - 1)), 8'($urandom_range(0, 255))});
    endtask

    // Sessions: round-robin over sources with bytes; a session ends on a last
    // byte, on the MAXB-th byte (truncation) or when the source runs dry (timeout).
    task automatic commit();
        int r, c, n;
        bit ended, any;
        logic [8:0] b;
        logic [1:0] evt;
        logic [N-1:0] oh;
        for (int i = 0; i < N; i++) mdl[i] = stg[i];
        any = 1;
        while (any) begin
            any = 0;
            r = -1;
            for (int k = 1; k <= N; k++) begin
                c = (model_last + k) % N;
                if (r < 0 && mdl[c].size() > 0) r = c;
            end
            if (r >= 0) begin
                any = 1; n = 0; ended = 0; evt = 2'b10;
                oh = '0; oh[r] = 1'b1;
                while (!ended && mdl[r].size() > 0) begin
                    b = mdl[r].pop_front();
                    exp_q.push_back({oh, b[7:0]});
                    n++;
                    if (b[8]) begin ended = 1; evt = 2'b00; end
                    else if (n == MAXB) begin ended = 1; evt = 2'b01; end
                end
                exp_evt_q.push_back(evt);
                model_last = r;
            end
        end
        for (int i = 0; i < N; i++) begin
            foreach (stg[i][j]) strm[i].push_back(stg[i][j]);
            stg[i].delete();
        end
        rise_pend = 1;
        rise_cyc  = cyc + 2;
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic [N-1:0] prev_grant;
        logic [N+7:0] e;
        logic [1:0]   ev;
        bit           hold_pend;
        logic [7:0]   hold_data;
        prev_grant = '0;
        hold_pend = 0;
        hold_data = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("grant_onehot0", 32'($onehot0(grant)), 1);
                chk("state_vs_grant", 32'(dbg_state), 32'(grant != '0));
                chk("req_ready", 32'(req_ready), 32'(grant & {N{tx_ready}}));
                chk("tx_valid", 32'(tx_valid), 32'(|(grant & req_valid)));
                if (hold_pend && tx_valid && grant == prev_grant)
                    chk("hold_data", 32'(tx_data), 32'(hold_data));
                if (tx_valid && tx_ready) begin
                    xfer_seen++;
                    if (exp_q.size() == 0) flag("unexpected_byte");
                    else begin
                        e = exp_q.pop_front();
                        chk("byte_owner_data", 32'({grant, tx_data}), 32'(e));
                    end
                end
                if (prev_grant != '0 && grant == '0) begin
                    if (exp_evt_q.size() == 0) flag("unexpected_release");
                    else begin
                        ev = exp_evt_q.pop_front();
                        chk("release_evt", 32'({timeout_evt, trunc_evt}), 32'(ev));
                        if (exp_evt_q.size() > 0) begin
                            rise_pend = 1;
                            rise_cyc  = cyc + 1;
                        end
                    end
                end else if (timeout_evt || trunc_evt) begin
                    flag("spurious_evt");
                end
                if (prev_grant == '0 && grant != '0) begin
                    if (!rise_pend) flag("spurious_grant");
                    else chk("grant_latency", 32'(cyc), 32'(rise_cyc));
                    rise_pend = 0;
                end
                hold_pend  = tx_valid && !tx_ready;
                hold_data  = tx_data;
                prev_grant = grant;
            end else begin
                prev_grant = '0;
                hold_pend  = 0;
            end
        end
    end

    // ---------------- scenario helpers ----------------
    function automatic bit streams_empty();
        for (int i = 0; i < N; i++) if (strm[i].size() > 0) return 0;
        return 1;
    endfunction

    task automatic do_reset();
        mon_en = 0;
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin strm[i].delete(); stg[i].delete(); gap_cnt[i] = 0; end
        exp_q.delete();
        exp_evt_q.delete();
        rise_pend = 0;
        @(negedge clk);
        #2;
        chk("rst_grant", 32'(grant), 0);
        chk("rst_tx_valid", 32'(tx_valid), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_events", 32'({timeout_evt, trunc_evt}), 0);
        chk("rst_state", 32'(dbg_state), 0);
        rst = 1'b0;
        model_last = N - 1;
        mon_en = 1;
    endtask

    task automatic wait_done(input string name);
        int n;
        bit done;
        n = 0;
        done = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            #2;
            n++;
            done = (exp_q.size() == 0) && (exp_evt_q.size() == 0) &&
                   (grant == '0) && streams_empty();
        end
        if (!done) begin
            flag({"scenario_stuck_", name});
            do_reset();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int base, n;
        bit any;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        do_reset();

        // single byte, then two interleave-prone messages
        add_str(0, "A", 1); commit(); wait_done("single");
        add_str(0, "ABC", 1); add_str(2, "xyz", 1); commit(); wait_done("two_msgs");

        // all four requesters, two messages each
        for (int r = 0; r < N; r++) begin add_rand(r, 3, 1); add_rand(r, 3, 1); end
        commit(); wait_done("all_four");

        // stalled transmitter pattern 1,0,0,1
        tx_mode = 1;
        add_str(1, "HEY", 1); add_str(3, "ok", 1); commit(); wait_done("stall");
        tx_mode = 0;

        // length-limit truncation, then idle timeout
        add_rand(1, 6, 0); add_str(2, "ok", 1); add_str(0, "z", 1); commit(); wait_done("trunc");
        add_rand(0, 1, 0); add_str(1, "hi", 1); commit(); wait_done("timeout");

        // reset during the 2nd byte of a 3-byte message
        do_reset();
        add_str(0, "ABC", 1); add_str(3, "Q", 1); commit();
        base = xfer_seen;
        n = 0;
        while (xfer_seen == base && n < 100) begin @(negedge clk); #2; n++; end
        if (xfer_seen == base) flag("reset_scn_no_first_byte");
        @(negedge clk);
        #2;
        do_reset();
        add_str(3, "M", 1); add_str(0, "L", 1); commit(); wait_done("after_reset");

        // randomised traffic
        gaps_en = 1;
        for (int round = 0; round < 30; round++) begin
            tx_mode = $urandom_range(0, 2);
            any = 0;
            for (int r = 0; r < N; r++) begin
                if ($urandom_range(0, 1) == 1) begin
                    any = 1;
                    for (int m = 0; m < $urandom_range(1, 2); m++)
                        add_rand(r, $urandom_range(1, 6), $urandom_range(0, 5) != 0);
                end
            end
            if (!any) add_rand($urandom_range(0, N - 1), $urandom_range(1, 5), 1);
            commit();
            wait_done("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
